// File: rtl/demux1_4.sv
// 1-to-4 valid/ready demux with one registered slot per channel.
// Optional per-channel transfer counters enabled by DEMUX_TX_COUNT_EN.
module demux1_4 #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [1:0]       IN_SEL,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT_DATA0,
    output logic [WIDTH-1:0] OUT_DATA1,
    output logic [WIDTH-1:0] OUT_DATA2,
    output logic [WIDTH-1:0] OUT_DATA3,
    output logic [3:0]       OUT_VALID,
    input  logic [3:0]       OUT_READY,
    output logic [31:0]      TX_CNT
);

    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_valid;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic [3:0]       w_load;
    logic [3:0]       w_out_xfer;

    // A full slot still accepts when it is being drained on the same edge.
    assign w_in_ready = ~r_valid[IN_SEL] | OUT_READY[IN_SEL];
    assign w_in_xfer  = IN_VALID & w_in_ready;
    assign w_out_xfer = r_valid & OUT_READY;

    always_comb begin
        w_load = 4'b0000;
        w_load[IN_SEL] = w_in_xfer;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid <= 4'b0000;
            for (int n = 0; n < 4; n++) begin
                r_data[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                r_valid[n] <= w_load[n] | (r_valid[n] & ~w_out_xfer[n]);
                if (w_load[n]) begin
                    r_data[n] <= IN_DATA;
                end
            end
        end
    end

`ifdef DEMUX_TX_COUNT_EN
    logic [7:0] r_cnt [4];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int n = 0; n < 4; n++) begin
                r_cnt[n] <= 8'd0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_out_xfer[n]) begin
                    r_cnt[n] <= r_cnt[n] + 8'd1;
                end
            end
        end
    end

    assign TX_CNT = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`else
    assign TX_CNT = 32'd0;
`endif

    assign IN_READY  = w_in_ready;
    assign OUT_VALID = r_valid;
    assign OUT_DATA0 = r_data[0];
    assign OUT_DATA1 = r_data[1];
    assign OUT_DATA2 = r_data[2];
    assign OUT_DATA3 = r_data[3];

endmodule

// File: tb/tb_demux1_4.sv
// Directed bench for demux1_4: routing, backpressure, throughput,
// concurrency, counters and asynchronous reset.
module tb_demux1_4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  IN_DATA;
    logic [1:0]  IN_SEL;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3;
    logic [3:0]  OUT_VALID;
    logic [3:0]  OUT_READY;
    logic [31:0] TX_CNT;

    int errors = 0;
    int checks = 0;

    demux1_4 #(.WIDTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_DATA(IN_DATA), .IN_SEL(IN_SEL),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_DATA0(OUT_DATA0), .OUT_DATA1(OUT_DATA1),
        .OUT_DATA2(OUT_DATA2), .OUT_DATA3(OUT_DATA3),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .TX_CNT(TX_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] dout(int n);
        case (n)
            0:       return OUT_DATA0;
            1:       return OUT_DATA1;
            2:       return OUT_DATA2;
            default: return OUT_DATA3;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        IN_VALID = 1'b0;
        OUT_READY = 4'b0000;
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        IN_DATA = 8'h00;
        IN_SEL = 2'd0;
        IN_VALID = 1'b0;
        OUT_READY = 4'b0000;
        #2;
        checks++;
        if (OUT_VALID !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0000", OUT_VALID);
        end
        checks++;
        if ({OUT_DATA3, OUT_DATA2, OUT_DATA1, OUT_DATA0} !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0",
                     {OUT_DATA3, OUT_DATA2, OUT_DATA1, OUT_DATA0});
        end
        checks++;
        if (TX_CNT !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %h expected 0", TX_CNT);
        end
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", IN_READY);
        end
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_routing();
        OUT_READY = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            IN_DATA = 8'(n);
            IN_SEL = 2'(n);
            IN_VALID = 1'b1;
            #1;
            checks++;
            if (IN_READY !== 1'b1) begin
                errors++;
                $display("FAIL route_ready%0d: got %b expected 1", n, IN_READY);
            end
            tick();
            checks++;
            if (OUT_VALID[n] !== 1'b1 || dout(n) !== 8'(n)) begin
                errors++;
                $display("FAIL route_ch%0d: got v=%b d=%h expected v=1 d=%h",
                         n, OUT_VALID[n], dout(n), 8'(n));
            end
        end
        IN_VALID = 1'b0;
        tick();
        checks++;
        if (OUT_VALID !== 4'b1111) begin
            errors++;
            $display("FAIL route_all: got %b expected 1111", OUT_VALID);
        end
    endtask

    task automatic test_backpressure();
        OUT_READY = 4'b0010;
        tick();
        OUT_READY = 4'b0000;
        checks++;
        if (OUT_VALID !== 4'b1101) begin
            errors++;
            $display("FAIL bp_drain1: got %b expected 1101", OUT_VALID);
        end
        IN_SEL = 2'd2;
        IN_DATA = 8'hFF;
        IN_VALID = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: got %b expected 0", IN_READY);
        end
        tick();
        checks++;
        if (OUT_DATA2 !== 8'h02 || OUT_VALID !== 4'b1101) begin
            errors++;
            $display("FAIL bp_hold: got d=%h v=%b expected d=02 v=1101",
                     OUT_DATA2, OUT_VALID);
        end
        IN_SEL = 2'd1;
        IN_DATA = 8'hA5;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL bp_other_ready: got %b expected 1", IN_READY);
        end
        tick();
        IN_VALID = 1'b0;
        checks++;
        if (OUT_DATA1 !== 8'hA5 || OUT_VALID !== 4'b1111) begin
            errors++;
            $display("FAIL bp_land: got d=%h v=%b expected d=a5 v=1111",
                     OUT_DATA1, OUT_VALID);
        end
    endtask

    task automatic test_concurrency();
        OUT_READY = 4'b1111;
        IN_SEL = 2'd1;
        IN_DATA = 8'h7E;
        IN_VALID = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL conc_ready: got %b expected 1", IN_READY);
        end
        tick();
        IN_VALID = 1'b0;
        OUT_READY = 4'b0000;
        checks++;
        if (OUT_VALID !== 4'b0010 || OUT_DATA1 !== 8'h7E) begin
            errors++;
            $display("FAIL conc: got v=%b d1=%h expected v=0010 d1=7e",
                     OUT_VALID, OUT_DATA1);
        end
        checks++;
        if (OUT_DATA0 !== 8'h00 || OUT_DATA2 !== 8'h02 || OUT_DATA3 !== 8'h03) begin
            errors++;
            $display("FAIL conc_retain: got %h %h %h expected 00 02 03",
                     OUT_DATA0, OUT_DATA2, OUT_DATA3);
        end
    endtask

    task automatic test_back_to_back();
        OUT_READY = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            IN_SEL = 2'd0;
            IN_DATA = 8'h10 + 8'(i);
            IN_VALID = 1'b1;
            #1;
            checks++;
            if (IN_READY !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b expected 1", i, IN_READY);
            end
            tick();
            checks++;
            if (OUT_VALID[0] !== 1'b1 || OUT_DATA0 !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL b2b_word%0d: got v=%b d=%h expected v=1 d=%h",
                         i, OUT_VALID[0], OUT_DATA0, 8'h10 + 8'(i));
            end
        end
        IN_VALID = 1'b0;
        tick();
        OUT_READY = 4'b0000;
        checks++;
        if (OUT_VALID !== 4'b0010 || OUT_DATA0 !== 8'h19) begin
            errors++;
            $display("FAIL b2b_drain: got v=%b d0=%h expected v=0010 d0=19",
                     OUT_VALID, OUT_DATA0);
        end
    endtask

    task automatic test_counter();
        logic [31:0] exp_mid;
        logic [31:0] exp_end;
`ifdef DEMUX_TX_COUNT_EN
        exp_mid = {8'd128, 24'd0};
        exp_end = {8'd4, 24'd0};
`else
        exp_mid = 32'd0;
        exp_end = 32'd0;
`endif
        do_reset();
        OUT_READY = 4'b1000;
        IN_SEL = 2'd3;
        IN_VALID = 1'b1;
        for (int i = 0; i < 260; i++) begin
            IN_DATA = 8'(i);
            tick();
            if (i == 128) begin
                checks++;
                if (TX_CNT !== exp_mid) begin
                    errors++;
                    $display("FAIL cnt_mid: got %h expected %h", TX_CNT, exp_mid);
                end
            end
        end
        IN_VALID = 1'b0;
        tick();
        OUT_READY = 4'b0000;
        checks++;
        if (TX_CNT !== exp_end || OUT_VALID !== 4'b0000) begin
            errors++;
            $display("FAIL cnt_end: got cnt=%h v=%b expected cnt=%h v=0000",
                     TX_CNT, OUT_VALID, exp_end);
        end
    endtask

    task automatic test_async_reset();
        OUT_READY = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            IN_SEL = 2'(n);
            IN_DATA = 8'hC0 + 8'(n);
            IN_VALID = 1'b1;
            tick();
        end
        IN_VALID = 1'b0;
        checks++;
        if (OUT_VALID !== 4'b1111 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL ar_fill: got v=%b rdy=%b expected v=1111 rdy=0",
                     OUT_VALID, IN_READY);
        end
        #3;
        RST_N = 1'b0;
        #1;
        checks++;
        if (OUT_VALID !== 4'b0000 || IN_READY !== 1'b1 || TX_CNT !== 32'd0 ||
            {OUT_DATA3, OUT_DATA2, OUT_DATA1, OUT_DATA0} !== 32'd0) begin
            errors++;
            $display("FAIL ar_clear: got v=%b rdy=%b cnt=%h d=%h expected 0000 1 0 0",
                     OUT_VALID, IN_READY, TX_CNT,
                     {OUT_DATA3, OUT_DATA2, OUT_DATA1, OUT_DATA0});
        end
        IN_SEL = 2'd2;
        IN_DATA = 8'h55;
        IN_VALID = 1'b1;
        tick();
        checks++;
        if (OUT_VALID !== 4'b0000 || OUT_DATA2 !== 8'h00) begin
            errors++;
            $display("FAIL ar_hold: got v=%b d2=%h expected v=0000 d2=00",
                     OUT_VALID, OUT_DATA2);
        end
        RST_N = 1'b1;
        tick();
        IN_VALID = 1'b0;
        checks++;
        if (OUT_VALID !== 4'b0100 || OUT_DATA2 !== 8'h55) begin
            errors++;
            $display("FAIL ar_release: got v=%b d2=%h expected v=0100 d2=55",
                     OUT_VALID, OUT_DATA2);
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_concurrency();
        test_back_to_back();
        test_counter();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux1_4.md
DEMUX1_4 -- requirements
Module: demux1_4

Interface
REQ-001 Parameter: WIDTH, default 8, data width of input and of each output channel.
REQ-002 Port: CLK  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: RST_N  input  1  asynchronous, active-low reset.
REQ-004 Port: IN_DATA  input  WIDTH  data word to route.
REQ-005 Port: IN_SEL  input  2  destination channel index, 0..3.
REQ-006 Port: IN_VALID  input  1  IN_DATA/IN_SEL valid this cycle.
REQ-007 Port: IN_READY  output  1  block accepts input this cycle.
REQ-008 Port: OUT_DATA0..OUT_DATA3  output  WIDTH each  per-channel registered data.
REQ-009 Port: OUT_VALID  output  4  bit n = OUT_DATAn holds an unconsumed word.
REQ-010 Port: OUT_READY  input  4  bit n = channel n consumer accepts this cycle.
REQ-011 Port: TX_CNT  output  32  four packed 8-bit per-channel transfer counts; channel n at bits [8n+7:8n].

Function
REQ-012 The block SHALL hold one single-entry register per channel (data + valid flag).
REQ-013 IN_READY SHALL be combinational: 1 when OUT_VALID[IN_SEL]=0 or OUT_READY[IN_SEL]=1; independent of IN_VALID.
REQ-014 Input transfer SHALL occur on a CLK edge where IN_VALID=1 and IN_READY=1.
REQ-015 On input transfer, channel IN_SEL register SHALL load IN_DATA and set OUT_VALID[IN_SEL]=1 at that edge (latency 1 cycle).
REQ-016 Output transfer on channel n SHALL occur on an edge where OUT_VALID[n]=1 and OUT_READY[n]=1.
REQ-017 Output transfer without a simultaneous input transfer to the same channel SHALL clear OUT_VALID[n] at that edge.
REQ-018 Simultaneous output transfer and input transfer on the same channel SHALL leave OUT_VALID[n]=1 and load the new word (full-throughput, no bubble).
REQ-019 Channels SHALL be independent: any number of channels may drain on the same edge.
REQ-020 OUT_DATAn SHALL hold its value while OUT_VALID[n]=1 and OUT_READY[n]=0.
REQ-021 OUT_DATAn SHALL retain its last value after drain; only OUT_VALID signals emptiness.
REQ-022 A full, stalled channel SHALL deassert IN_READY only when IN_SEL selects it; other selections remain accepted.
REQ-023 Data SHALL never be dropped or duplicated; words per channel SHALL emerge in arrival order.
REQ-024 IN_SEL or IN_DATA changes while IN_VALID=0 SHALL have no effect.

Reset
REQ-025 RST_N=0 SHALL immediately clear OUT_VALID to 4'b0000, OUT_DATA0..3 to 0, TX_CNT to 0, regardless of CLK.
REQ-026 Reset mid-operation SHALL discard all buffered words; IN_READY SHALL read 1 during and after reset.
REQ-027 Deassertion of RST_N SHALL take effect at the next rising CLK edge; no transfer occurs on an edge while RST_N=0.

Configuration
REQ-028 Macro DEMUX_TX_COUNT_EN SHALL control the transfer counters.
REQ-029 With DEMUX_TX_COUNT_EN defined, counter n SHALL increment by 1 on each output transfer of channel n, wrapping 255->0.
REQ-030 Without DEMUX_TX_COUNT_EN, TX_CNT SHALL be driven constant 0, no counter registers instantiated; all other behaviour identical.

Verification
REQ-031 Reset: RST_N=0 asynchronously mid-cycle with channels full -> OUT_VALID=0000, OUT_DATA0..3=0, TX_CNT=0, IN_READY=1 immediately.
REQ-032 Routing: OUT_READY=0000, send 8'h00/sel0, 8'h01/sel1, 8'h02/sel2, 8'h03/sel3 -> OUT_VALID=1111, OUT_DATAn=n, one cycle after each accept.
REQ-033 Backpressure: channel 2 full, OUT_READY[2]=0, IN_SEL=2, IN_VALID=1 -> IN_READY=0, OUT_DATA2 unchanged; switch IN_SEL=1 -> IN_READY=1, 8'hA5 lands on OUT_DATA1.
REQ-034 Throughput: OUT_READY[0]=1, 10 back-to-back words 8'h10..8'h19 on sel 0 -> IN_READY stays 1, OUT_DATA0 sequence 10..19, no bubbles.
REQ-035 Counter (macro defined): 260 output transfers on channel 3 -> TX_CNT[31:24]=8'd4, other fields 0; macro undefined -> TX_CNT=0 throughout.
REQ-036 Concurrency: all four channels full, OUT_READY=1111 plus input 8'h7E/sel1 same edge -> OUT_VALID=0010, OUT_DATA1=8'h7E.
